// File: rtl/apb_mem_arbiter_pkg.sv
// Shared types and constants for the imem/dmem APB memory arbiter.
package apb_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_SETUP  = 2'd1,
        ARB_ACCESS = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_IMEM = 2'b01,
        GNT_DMEM = 2'b10
    } arb_grant_e;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    localparam int CONSEC_W = 4;
    localparam int TMO_W    = 8;

endpackage

// File: rtl/apb_if.sv
// Plain APB bus bundle with requester-facing and memory-facing views.
interface apb_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                    output prdata, pready, pslverr);
    modport master (output psel, penable, pwrite, paddr, pwdata,
                    input  prdata, pready, pslverr);
endinterface

// File: rtl/apb_arb_picker.sv
// Combinational winner selection between imem and dmem requests.
module apb_arb_picker
    import apb_mem_arbiter_pkg::*;
#(
    parameter int ARB_MODE        = ARB_RR,
    parameter int DMEM_MAX_CONSEC = 4
) (
    input  logic                i_req_imem,
    input  logic                i_req_dmem,
    input  logic [1:0]          i_excl,
    input  logic                i_rr_ptr,
    input  logic [CONSEC_W-1:0] i_consec,
    output arb_grant_e          o_winner
);

    localparam logic [CONSEC_W-1:0] MAX_CONSEC = CONSEC_W'(DMEM_MAX_CONSEC);

    logic w_imem;
    logic w_dmem;

    // A master finishing this cycle still shows psel, so it is masked out.
    assign w_imem = i_req_imem & ~i_excl[0];
    assign w_dmem = i_req_dmem & ~i_excl[1];

    // Resolve ties by mode: RR pointer, or dmem first until the streak bound.
    always_comb begin
        o_winner = GNT_NONE;
        if (w_imem && w_dmem) begin
            if (ARB_MODE == ARB_FIXED) begin
                if (i_consec >= MAX_CONSEC) begin
                    o_winner = GNT_IMEM;
                end else begin
                    o_winner = GNT_DMEM;
                end
            end else begin
                if (i_rr_ptr) begin
                    o_winner = GNT_DMEM;
                end else begin
                    o_winner = GNT_IMEM;
                end
            end
        end else if (w_imem) begin
            o_winner = GNT_IMEM;
        end else if (w_dmem) begin
            o_winner = GNT_DMEM;
        end else begin
            o_winner = GNT_NONE;
        end
    end

endmodule

// File: rtl/apb_mem_arbiter.sv
// Shares one APB memory between imem and dmem requesters, with
// back-to-back handoff, selectable arbitration and an access timeout.
module apb_mem_arbiter
    import apb_mem_arbiter_pkg::*;
#(
    parameter int ARB_MODE        = ARB_RR,
    parameter int DMEM_MAX_CONSEC = 4,
    parameter int TIMEOUT         = 64
) (
    input  logic       clk,
    input  logic       rst,
    apb_if.slave       imem_s,
    apb_if.slave       dmem_s,
    apb_if.master      mem_m,
    output logic [1:0] grant_o,
    output logic       timeout_o
);

    localparam bit               TMO_EN   = (TIMEOUT != 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    arb_state_e          r_state, w_state_nxt;
    arb_grant_e          r_grant, w_grant_nxt, w_winner;
    logic                r_psel, w_psel_nxt;
    logic                r_penable, w_penable_nxt;
    logic                r_pwrite, w_pwrite_nxt;
    logic [31:0]         r_paddr, w_paddr_nxt;
    logic [31:0]         r_pwdata, w_pwdata_nxt;
    logic                r_rr_ptr;
    logic [CONSEC_W-1:0] r_consec;
    logic [TMO_W-1:0]    r_tmo_cnt;
    logic                w_timeout, w_done, w_take, w_imem_pend;
    logic [1:0]          w_excl;
    logic                w_sel_pwrite;
    logic [31:0]         w_sel_paddr, w_sel_pwdata;

    assign w_excl      = (r_state == ARB_ACCESS) ? r_grant : GNT_NONE;
    assign w_imem_pend = imem_s.psel & ~w_excl[0];

    apb_arb_picker #(
        .ARB_MODE        (ARB_MODE),
        .DMEM_MAX_CONSEC (DMEM_MAX_CONSEC)
    ) u_picker (
        .i_req_imem (imem_s.psel),
        .i_req_dmem (dmem_s.psel),
        .i_excl     (w_excl),
        .i_rr_ptr   (r_rr_ptr),
        .i_consec   (r_consec),
        .o_winner   (w_winner)
    );

    // Detect the completion cycle: slave ready, or the access has hung too long.
    always_comb begin
        w_timeout = 1'b0;
        if (TMO_EN && (r_state == ARB_ACCESS) && !mem_m.pready && (r_tmo_cnt == TMO_LAST)) begin
            w_timeout = 1'b1;
        end else begin
            w_timeout = 1'b0;
        end
        w_done = (r_state == ARB_ACCESS) && (mem_m.pready || w_timeout);
    end

    // Route the winning requester's transfer fields toward the memory side.
    always_comb begin
        w_sel_pwrite = imem_s.pwrite;
        w_sel_paddr  = imem_s.paddr;
        w_sel_pwdata = imem_s.pwdata;
        if (w_winner == GNT_DMEM) begin
            w_sel_pwrite = dmem_s.pwrite;
            w_sel_paddr  = dmem_s.paddr;
            w_sel_pwdata = dmem_s.pwdata;
        end else begin
            w_sel_pwrite = imem_s.pwrite;
            w_sel_paddr  = imem_s.paddr;
            w_sel_pwdata = imem_s.pwdata;
        end
    end

    // Next-state logic: IDLE grants, SETUP raises penable, ACCESS hands off or idles.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_psel_nxt    = r_psel;
        w_penable_nxt = r_penable;
        w_pwrite_nxt  = r_pwrite;
        w_paddr_nxt   = r_paddr;
        w_pwdata_nxt  = r_pwdata;
        w_take        = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_winner != GNT_NONE) begin
                    w_take = 1'b1;
                end else begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            ARB_SETUP: begin
                w_penable_nxt = 1'b1;
                w_state_nxt   = ARB_ACCESS;
            end
            ARB_ACCESS: begin
                if (w_done && (w_winner != GNT_NONE)) begin
                    w_take = 1'b1;
                end else if (w_done) begin
                    w_state_nxt   = ARB_IDLE;
                    w_psel_nxt    = 1'b0;
                    w_penable_nxt = 1'b0;
                    w_grant_nxt   = GNT_NONE;
                end else begin
                    w_state_nxt = ARB_ACCESS;
                end
            end
            default: begin
                w_state_nxt   = ARB_IDLE;
                w_psel_nxt    = 1'b0;
                w_penable_nxt = 1'b0;
                w_grant_nxt   = GNT_NONE;
            end
        endcase
        if (w_take) begin
            w_state_nxt   = ARB_SETUP;
            w_grant_nxt   = w_winner;
            w_psel_nxt    = 1'b1;
            w_penable_nxt = 1'b0;
            w_pwrite_nxt  = w_sel_pwrite;
            w_paddr_nxt   = w_sel_paddr;
            w_pwdata_nxt  = w_sel_pwdata;
        end else begin
            w_state_nxt = w_state_nxt;
        end
    end

    // State and memory-side bus registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ARB_IDLE;
            r_grant   <= GNT_NONE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= 32'd0;
            r_pwdata  <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_psel    <= w_psel_nxt;
            r_penable <= w_penable_nxt;
            r_pwrite  <= w_pwrite_nxt;
            r_paddr   <= w_paddr_nxt;
            r_pwdata  <= w_pwdata_nxt;
        end
    end

    // Arbitration history: RR pointer and dmem streak while imem waits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= 1'b0;
            r_consec <= {CONSEC_W{1'b0}};
        end else if (w_take) begin
            r_rr_ptr <= (w_winner == GNT_IMEM);
            if (w_winner == GNT_IMEM) begin
                r_consec <= {CONSEC_W{1'b0}};
            end else if (w_imem_pend && (r_consec != {CONSEC_W{1'b1}})) begin
                r_consec <= r_consec + 4'd1;
            end
        end
    end

    // Count ACCESS cycles spent waiting for the slave.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= {TMO_W{1'b0}};
        end else if ((r_state == ARB_ACCESS) && !w_done) begin
            if (r_tmo_cnt != {TMO_W{1'b1}}) begin
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end
        end else begin
            r_tmo_cnt <= {TMO_W{1'b0}};
        end
    end

    assign mem_m.psel    = r_psel;
    assign mem_m.penable = r_penable;
    assign mem_m.pwrite  = r_pwrite;
    assign mem_m.paddr   = r_paddr;
    assign mem_m.pwdata  = r_pwdata;

    // Upstream handshake exists only in the owner's completion cycle.
    assign imem_s.pready  = w_done && (r_grant == GNT_IMEM);
    assign dmem_s.pready  = w_done && (r_grant == GNT_DMEM);
    assign imem_s.pslverr = w_done && (r_grant == GNT_IMEM) && (w_timeout || mem_m.pslverr);
    assign dmem_s.pslverr = w_done && (r_grant == GNT_DMEM) && (w_timeout || mem_m.pslverr);
    assign imem_s.prdata  = w_timeout ? 32'd0 : mem_m.prdata;
    assign dmem_s.prdata  = w_timeout ? 32'd0 : mem_m.prdata;

    assign grant_o   = r_grant;
    assign timeout_o = w_timeout;

endmodule

// File: doc/apb_mem_arbiter.md
Name: apb_mem_arbiter

Overview:
- Shares one APB memory slave between the core's two APB masters: instruction fetch (imem) and load/store (dmem).
- Sits between the core's imem/dmem APB master ports and a single unified memory.
- Sequences downstream SETUP/ACCESS phases and stalls the losing requester by holding its PREADY low.
- Arbitrates round-robin or dmem-priority with a starvation bound, and aborts hung accesses with a timeout error.

Parameters:
- ARB_MODE, 0: 0 = round-robin; 1 = dmem fixed priority with starvation bound.
- DMEM_MAX_CONSEC, 4: ARB_MODE=1 only. Maximum consecutive dmem grants while imem is pending; range 1..15.
- TIMEOUT, 64: maximum ACCESS cycles before abort. 0 disables the timeout. Counter is 8 bits, so TIMEOUT ≤ 255.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- imem_s  apb_if.slave  -  fetch requester. Fields: psel, penable, pwrite, paddr[31:0], pwdata[31:0], prdata[31:0], pready, pslverr.
- dmem_s  apb_if.slave  -  load/store requester. Same fields as imem_s.
- mem_m  apb_if.master  -  shared memory. Same fields as imem_s.
- grant_o  output  2  current owner: 00 none, 01 imem, 10 dmem.
- timeout_o  output  1  one-cycle pulse when an access is aborted.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - mem_m.psel, penable, pwrite, paddr, pwdata are all 0.
  - Both upstream pready and pslverr are 0.
  - grant_o=00, timeout_o=0, round-robin pointer points to imem, consecutive counter is 0, timeout counter is 0.
  - A reset mid-transfer abandons the transfer silently; no pready is issued.
- Request: req_x = x_s.psel. Requesters follow APB and hold paddr/pwrite/pwdata stable until they see pready.
- FSM, fully registered on the mem_m side:
  - IDLE: if any request, pick a winner, latch its paddr/pwrite/pwdata into mem_m, set psel=1 and penable=0, set grant_o, go to SETUP.
  - SETUP: set penable=1, go to ACCESS.
  - ACCESS, when mem_m.pready=1:
    - Completion cycle: winner's pready = 1 (combinational from mem_m.pready); winner's pslverr = mem_m.pslverr.
    - Next cycle: if the other master is requesting, grant it and go straight to SETUP (back-to-back, psel stays 1). Otherwise psel=0, penable=0, go to IDLE.
    - The just-completed master is excluded from arbitration in its completion cycle, because its psel is still high there.
  - ACCESS, on timeout (TIMEOUT≠0, counter reaches TIMEOUT-1 with no mem_m.pready):
    - Winner receives pready=1, pslverr=1, prdata=0 for one cycle.
    - timeout_o pulses for one cycle.
    - mem_m psel/penable drop next cycle and the FSM continues as for a normal completion.
- Upstream pready and pslverr are 0 for the non-granted master and for every cycle other than the completion cycle.
- prdata: mem_m.prdata is broadcast to both upstream ports. It is meaningful only alongside that port's pready.
- Latency: request seen in cycle 0 → SETUP in cycle 1 → ACCESS in cycle 2. With a zero-wait slave, completion is in cycle 2, i.e. 3 cycles total.
- Round-robin:
  - On a tie, the master not granted last wins.
  - The pointer updates at grant.
- Fixed priority:
  - dmem wins ties.
  - The consecutive counter increments on a dmem grant while imem is pending and clears on an imem grant.
  - When the counter equals DMEM_MAX_CONSEC and imem is pending, imem wins.
- Simultaneous requests arriving in IDLE are resolved by the rules above.
- A requester dropping psel without seeing pready is a protocol violation; the transfer still completes normally.

Decomposition:
- Shared package (typedefs):
  - arb_state_e {ARB_IDLE, ARB_SETUP, ARB_ACCESS}.
  - arb_grant_e {GNT_NONE=2'b00, GNT_IMEM=2'b01, GNT_DMEM=2'b10}.
  - ARB_RR and ARB_FIXED mode constants.
- One sub-module: apb_arb_picker. It is combinational and derives the winner from both requests, the exclude mask, the RR pointer, the consecutive counter and the mode.
- FSM, counters and muxing live in the top module.

Test Plan:
- Single imem read at 0x0000_0100, zero-wait slave returning 0xDEAD_BEEF → mem_m SETUP in cycle 1, ACCESS in cycle 2; imem pready=1 with prdata=0xDEAD_BEEF in cycle 2; dmem pready stays 0.
- imem and dmem request in the same cycle, ARB_MODE=0, pointer at imem → imem served first; dmem goes SETUP the cycle after imem completes, with no IDLE gap; grant_o sequence is 01, then 10.
- ARB_MODE=1, DMEM_MAX_CONSEC=2, dmem continuously requesting, imem pending → grants run dmem, dmem, imem, dmem, dmem, imem.
- Write from dmem (paddr=0x8, pwdata=0x1234_5678), slave with 3 wait states → mem_m fields held stable for 5 cycles; dmem pready high only on the final cycle; pslverr=0.
- TIMEOUT=4, slave never asserts pready → winner gets pready=1, pslverr=1, prdata=0 in the 4th ACCESS cycle; timeout_o pulses; next cycle mem_m.psel=0.
- Assert rst during ACCESS of an imem transfer → all outputs go to 0 immediately; state is IDLE; after release, the pending dmem request is granted normally.
